// File: rtl/bus_responder_pkg.sv
// Shared constants, decode type and write-merge helper for bus_responder.
package bus_responder_pkg;

  localparam logic [7:0] ADDR_GPIO      = 8'hF0;
  localparam logic [7:0] ADDR_TMR_COUNT = 8'hF1;
  localparam logic [7:0] ADDR_TMR_CMP   = 8'hF2;
  localparam logic [7:0] ADDR_TMR_CTRL  = 8'hF3;
  localparam logic [7:0] ADDR_ID        = 8'hF4;

  localparam logic [7:0] ID_VALUE = 8'h5A;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_FLAG_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  // Which register region the current address selects.
  typedef enum logic [2:0] {
    SelNone,
    SelRam,
    SelGpio,
    SelCount,
    SelCmp,
    SelCtrl,
    SelId
  } region_e;

  // Bits set in wmask take wdata, the rest keep old_val.
  function automatic logic [7:0] masked_merge(input logic [7:0] old_val,
                                              input logic [7:0] wdata,
                                              input logic [7:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-side bus of bus_responder: address, per-bit write mask, write data and
// the registered read response.
interface bus_responder_if;
  logic [7:0] address;
  logic [7:0] write_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;

  modport master (
    output address,
    output write_enable,
    output write_data,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_enable,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/bus_timer.sv
// Free-running 8-bit timer with compare match flag (write-1-to-clear) and
// interrupt enable. CPU writes arrive as per-register strobes plus mask/data.
module bus_timer
  import bus_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       count_we_i,
  input  logic       cmp_we_i,
  input  logic       ctrl_we_i,
  input  logic [7:0] wmask_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] count_o,
  output logic [7:0] cmp_o,
  output logic [7:0] ctrl_o,
  output logic       irq_o
);

  logic [7:0] count_q, count_d;
  logic [7:0] cmp_q, cmp_d;
  logic       en_q, en_d;
  logic       flag_q, flag_d;
  logic       ie_q, ie_d;
  logic [7:0] count_inc;
  logic       match;

  // Next-state: CPU count write beats increment; a match set beats a W1C clear.
  always_comb begin
    count_d   = count_q;
    cmp_d     = cmp_q;
    en_d      = en_q;
    flag_d    = flag_q;
    ie_d      = ie_q;
    match     = 1'b0;
    count_inc = count_q + 8'd1;

    if (count_we_i) begin
      count_d = masked_merge(count_q, wdata_i, wmask_i);
    end else if (en_q) begin
      count_d = count_inc;
      match   = (count_inc == cmp_q);
    end

    if (cmp_we_i) begin
      cmp_d = masked_merge(cmp_q, wdata_i, wmask_i);
    end

    if (ctrl_we_i) begin
      en_d = (en_q & ~wmask_i[CTRL_EN_BIT]) | (wdata_i[CTRL_EN_BIT] & wmask_i[CTRL_EN_BIT]);
      ie_d = (ie_q & ~wmask_i[CTRL_IRQ_EN_BIT])
           | (wdata_i[CTRL_IRQ_EN_BIT] & wmask_i[CTRL_IRQ_EN_BIT]);
      if (wmask_i[CTRL_FLAG_BIT] && wdata_i[CTRL_FLAG_BIT]) begin
        flag_d = 1'b0;
      end
    end

    if (match) begin
      flag_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
      ie_q    <= ie_d;
    end
  end

  // Control readback; bits 7:3 are always zero.
  always_comb begin
    ctrl_o                  = '0;
    ctrl_o[CTRL_EN_BIT]     = en_q;
    ctrl_o[CTRL_FLAG_BIT]   = flag_q;
    ctrl_o[CTRL_IRQ_EN_BIT] = ie_q;
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign irq_o   = flag_q & ie_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped responder: RAM at 0x00, GPIO_OUT, ID and an optional timer.
// The timer block is present only when BUS_RESPONDER_TIMER_EN is defined;
// otherwise its addresses read 0x00, ignore writes and irq is tied low.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_responder_if.slave        bus,
  output logic [7:0]            gpio_out,
  output logic                  irq
);

  localparam int unsigned AW = $clog2(RAM_BYTES);

  region_e       sel;
  logic [AW-1:0] ram_idx;
  logic          wr_active;
  logic [7:0]    wr_merged;

  logic [7:0] read_data_q, read_data_d;
  logic [7:0] gpio_q, gpio_d;
  logic [7:0] ram_q [RAM_BYTES];
  logic [7:0] ram_d [RAM_BYTES];

  // Address decode; RAM wins below RAM_BYTES, no aliasing above it.
  always_comb begin
    sel = SelNone;
    if ({1'b0, bus.address} < 9'(RAM_BYTES)) begin
      sel = SelRam;
    end else begin
      case (bus.address)
        ADDR_GPIO:      sel = SelGpio;
        ADDR_TMR_COUNT: sel = SelCount;
        ADDR_TMR_CMP:   sel = SelCmp;
        ADDR_TMR_CTRL:  sel = SelCtrl;
        ADDR_ID:        sel = SelId;
        default:        sel = SelNone;
      endcase
    end
  end

  assign ram_idx   = bus.address[AW-1:0];
  assign wr_active = |bus.write_enable;

`ifdef BUS_RESPONDER_TIMER_EN
  logic [7:0] tmr_count;
  logic [7:0] tmr_cmp;
  logic [7:0] tmr_ctrl;

  bus_timer u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .count_we_i (wr_active && (sel == SelCount)),
    .cmp_we_i   (wr_active && (sel == SelCmp)),
    .ctrl_we_i  (wr_active && (sel == SelCtrl)),
    .wmask_i    (bus.write_enable),
    .wdata_i    (bus.write_data),
    .count_o    (tmr_count),
    .cmp_o      (tmr_cmp),
    .ctrl_o     (tmr_ctrl),
    .irq_o      (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // Read mux over pre-write state, so a read during a write returns old data.
  always_comb begin
    read_data_d = '0;
    unique case (sel)
      SelRam:   read_data_d = ram_q[ram_idx];
      SelGpio:  read_data_d = gpio_q;
      SelId:    read_data_d = ID_VALUE;
`ifdef BUS_RESPONDER_TIMER_EN
      SelCount: read_data_d = tmr_count;
      SelCmp:   read_data_d = tmr_cmp;
      SelCtrl:  read_data_d = tmr_ctrl;
`endif
      default:  read_data_d = '0;
    endcase
  end

  // Masked write into GPIO_OUT or one RAM byte.
  always_comb begin
    gpio_d    = gpio_q;
    ram_d     = ram_q;
    wr_merged = masked_merge(ram_q[ram_idx], bus.write_data, bus.write_enable);
    if (wr_active) begin
      if (sel == SelGpio) begin
        gpio_d = masked_merge(gpio_q, bus.write_data, bus.write_enable);
      end
      if (sel == SelRam) begin
        ram_d[ram_idx] = wr_merged;
      end
    end
  end

  // Responder state; reset clears RAM as well as the registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data_q <= '0;
      gpio_q      <= '0;
      for (int i = 0; i < RAM_BYTES; i++) begin
        ram_q[i] <= '0;
      end
    end else begin
      read_data_q <= read_data_d;
      gpio_q      <= gpio_d;
      ram_q       <= ram_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign gpio_out      = gpio_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed scenarios followed by
// random bus traffic, all checked against a register-level reference model.
module tb_bus_responder;

  localparam int unsigned RB = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] gpio_out;
  logic irq;

  bus_responder_if bus ();

  bus_responder #(.RAM_BYTES(RB)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] m_ram [RB];
  logic [7:0] m_gpio;
  logic [7:0] m_cnt;
  logic [7:0] m_cmp;
  logic       m_en, m_flag, m_ie;
  logic [7:0] exp_rd;

  function automatic logic [7:0] merge(input logic [7:0] o, input logic [7:0] m,
                                       input logic [7:0] d);
    return (o & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(RB); i++) m_ram[i] = 8'h00;
    m_gpio = 8'h00;
    m_cnt  = 8'h00;
    m_cmp  = 8'h00;
    m_en   = 1'b0;
    m_flag = 1'b0;
    m_ie   = 1'b0;
    exp_rd = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (int'(a) < int'(RB)) return m_ram[int'(a)];
    case (a)
      8'hF0: return m_gpio;
      8'hF4: return 8'h5A;
`ifdef BUS_RESPONDER_TIMER_EN
      8'hF1: return m_cnt;
      8'hF2: return m_cmp;
      8'hF3: return {5'b00000, m_ie, m_flag, m_en};
`endif
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_irq();
`ifdef BUS_RESPONDER_TIMER_EN
    return m_flag & m_ie;
`else
    return 1'b0;
`endif
  endfunction

  // One rising edge: the read sees the old contents, then writes and the timer apply.
  task automatic model_edge(input logic [7:0] a, input logic [7:0] m, input logic [7:0] d);
    logic       wr;
    logic       old_en;
    logic [7:0] old_cmp;
    logic       hit;
    exp_rd  = model_read(a);
    wr      = (m != 8'h00);
    old_en  = m_en;
    old_cmp = m_cmp;
    hit     = 1'b0;
    if (wr && int'(a) < int'(RB)) m_ram[int'(a)] = merge(m_ram[int'(a)], m, d);
    if (wr && a == 8'hF0) m_gpio = merge(m_gpio, m, d);
`ifdef BUS_RESPONDER_TIMER_EN
    if (wr && a == 8'hF1) begin
      m_cnt = merge(m_cnt, m, d);
    end else if (old_en) begin
      m_cnt = m_cnt + 8'd1;
      hit   = (m_cnt == old_cmp);
    end
    if (wr && a == 8'hF2) m_cmp = merge(m_cmp, m, d);
    if (wr && a == 8'hF3) begin
      m_en = (m_en & ~m[0]) | (d[0] & m[0]);
      m_ie = (m_ie & ~m[2]) | (d[2] & m[2]);
      if (m[1] && d[1]) m_flag = 1'b0;
    end
    if (hit) m_flag = 1'b1;
`endif
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle away from the edge, clock it, sample 1 ns later.
  task automatic step(input logic [7:0] a, input logic [7:0] m, input logic [7:0] d);
    bus.address      = a;
    bus.write_enable = m;
    bus.write_data   = d;
    @(posedge clock);
    model_edge(a, m, d);
    #1;
    check("read_data", bus.read_data, exp_rd);
    check("gpio_out", gpio_out, m_gpio);
    check("irq", {7'b0, irq}, {7'b0, model_irq()});
  endtask

  initial begin
    logic [7:0] a, m, d;
    int unsigned r;

    bus.address      = 8'h00;
    bus.write_enable = 8'h00;
    bus.write_data   = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset read_data", bus.read_data, 8'h00);
    check("reset gpio_out", gpio_out, 8'h00);
    check("reset irq", {7'b0, irq}, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // Masked write sequence on RAM byte 0x10.
    step(8'h10, 8'h0F, 8'hFF);
    step(8'h10, 8'h03, 8'h00);
    step(8'h10, 8'h00, 8'h00);
    check("masked write readback", bus.read_data, 8'h0C);

    // Read-old-data on RAM byte 0x05.
    step(8'h05, 8'hFF, 8'h11);
    step(8'h05, 8'hFF, 8'h22);
    check("read old data", bus.read_data, 8'h11);
    step(8'h05, 8'h00, 8'h00);
    check("read new data", bus.read_data, 8'h22);

    // Unmapped addresses read zero and drop writes.
    step(8'h80, 8'hFF, 8'h77);
    step(8'h80, 8'h00, 8'h00);
    check("unmapped 0x80", bus.read_data, 8'h00);
    step(8'h20, 8'hFF, 8'h99);
    step(8'h00, 8'h00, 8'h00);
    step(8'h20, 8'h00, 8'h00);
    check("no alias past RAM", bus.read_data, 8'h00);

    // ID is read-only.
    step(8'hF4, 8'hFF, 8'h00);
    step(8'hF4, 8'h00, 8'h00);
    check("id read-only", bus.read_data, 8'h5A);

`ifdef BUS_RESPONDER_TIMER_EN
    // Compare match on the third enabled edge, then W1C clears irq.
    step(8'hF2, 8'hFF, 8'h03);
    step(8'hF3, 8'hFF, 8'h05);
    step(8'hF1, 8'h00, 8'h00);
    step(8'hF1, 8'h00, 8'h00);
    step(8'hF1, 8'h00, 8'h00);
    check("match irq set", {7'b0, irq}, 8'h01);
    step(8'hF3, 8'hFF, 8'h07);
    check("w1c irq clear", {7'b0, irq}, 8'h00);

    // Wrap from 0xFE through 0xFF to 0x00 with compare at zero.
    step(8'hF3, 8'hFF, 8'h00);
    step(8'hF2, 8'hFF, 8'h00);
    step(8'hF1, 8'hFF, 8'hFE);
    step(8'hF3, 8'hFF, 8'h01);
    step(8'hF1, 8'h00, 8'h00);
    step(8'hF1, 8'h00, 8'h00);
    check("wrap reads 0xFF", bus.read_data, 8'hFF);
    step(8'hF1, 8'h00, 8'h00);
    check("wrap reads 0x00", bus.read_data, 8'h00);
    step(8'hF3, 8'h00, 8'h00);
    check("flag set on wrap", bus.read_data & 8'h02, 8'h02);
    step(8'hF3, 8'hFF, 8'h02);
`else
    // Timer registers compiled out.
    step(8'hF2, 8'hFF, 8'h33);
    step(8'hF2, 8'h00, 8'h00);
    check("cmp compiled out", bus.read_data, 8'h00);
    step(8'hF3, 8'hFF, 8'h07);
    step(8'hF3, 8'h00, 8'h00);
    check("ctrl compiled out", bus.read_data, 8'h00);
    check("irq tied low", {7'b0, irq}, 8'h00);
`endif

    // Reset asserted mid-write to GPIO_OUT discards the write.
    step(8'hF0, 8'hFF, 8'h3C);
    bus.address      = 8'hF0;
    bus.write_enable = 8'hFF;
    bus.write_data   = 8'hA5;
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    check("gpio after reset", gpio_out, 8'h00);
    check("read_data in reset", bus.read_data, 8'h00);
    check("irq in reset", {7'b0, irq}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    step(8'hF4, 8'h00, 8'h00);
    check("id after reset", bus.read_data, 8'h5A);
    step(8'h05, 8'h00, 8'h00);
    check("ram cleared by reset", bus.read_data, 8'h00);
    step(8'hF0, 8'hFF, 8'h96);
    check("first write after reset", gpio_out, 8'h96);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(9, 0);
      if (r < 5)       a = 8'($urandom_range(RB - 1, 0));
      else if (r < 8)  a = 8'($urandom_range(8'hF4, 8'hF0));
      else if (r == 8) a = 8'($urandom_range(255, 0));
      else             a = 8'($urandom_range(8'hEF, RB));
      m = ($urandom_range(2, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 0));
      d = 8'($urandom_range(255, 0));
      step(a, m, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 32, meaning RAM size at address 0x00; power of two, 8 to 128 inclusive.
REQ-002 SHALL have port clock, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port address, input, 8 bits, byte address driven by the CPU.
REQ-005 SHALL have port write_enable, input, 8 bits, per-bit write mask; a write is active when it is non-zero.
REQ-006 SHALL have port write_data, input, 8 bits, CPU write data.
REQ-007 SHALL have port read_data, output, 8 bits, registered response data.
REQ-008 SHALL have port gpio_out, output, 8 bits, the GPIO_OUT register.
REQ-009 SHALL have port irq, output, 1 bit, the timer interrupt request.

Function
REQ-010 SHALL use the following address map:
- 0x00 to RAM_BYTES-1: RAM.
- 0xF0: GPIO_OUT, RW.
- 0xF1: TMR_COUNT, RW.
- 0xF2: TMR_CMP, RW.
- 0xF3: TMR_CTRL (bit0 enable, bit1 match flag, bit2 irq enable, bits 7:3 read 0).
- 0xF4: ID, read-only, 0x5A.
- All other addresses: read 0x00, writes ignored.
REQ-011 SHALL update a writable location on an active write as new = (old & ~write_enable) | (write_data & write_enable).
REQ-012 SHALL load read_data at each rising edge with the contents of address sampled at that edge, as held before that edge's write (read-old-data); read latency is exactly one cycle.
REQ-013 SHALL make read_data follow address on every cycle, whether or not a write is active.
REQ-014 SHALL ignore writes to ID and to TMR_CTRL bits 7:3.
REQ-015 SHALL treat TMR_CTRL bit1 as write-1-to-clear: a masked-in 1 clears the flag; a 0 has no effect.
REQ-016 SHALL increment TMR_COUNT by 1 each cycle while enable=1, wrapping 0xFF to 0x00.
REQ-017 SHALL set the match flag on the edge where the incremented count equals TMR_CMP.
REQ-018 SHALL let a CPU write to TMR_COUNT take priority over increment in the same cycle; no match evaluation occurs in that cycle.
REQ-019 SHALL keep the flag set when a flag set and a W1C clear occur in the same cycle (set wins).
REQ-020 SHALL drive irq combinationally as flag AND irq-enable.
REQ-021 SHALL alias RAM addresses modulo 256 only; addresses in RAM_BYTES to 0xEF are unmapped.

Reset
REQ-022 SHALL asynchronously clear the following on reset: read_data, gpio_out, TMR_COUNT, TMR_CMP, TMR_CTRL, all RAM bytes; irq is therefore 0.
REQ-023 SHALL block all updates during reset; a write pending when reset asserts is discarded.
REQ-024 SHALL accept the first write on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL, with BUS_RESPONDER_TIMER_EN defined, implement TMR_COUNT, TMR_CMP, TMR_CTRL and irq as specified.
REQ-026 SHALL, without BUS_RESPONDER_TIMER_EN, read 0xF1 to 0xF3 as 0x00, ignore writes to them, tie irq to 0, and contain no timer flops.

Structure
REQ-027 SHALL take the address constants (ADDR_GPIO, ADDR_TMR_COUNT, ADDR_TMR_CMP, ADDR_TMR_CTRL, ADDR_ID), ID_VALUE and TMR_CTRL bit indices from shared package bus_responder_pkg.
REQ-028 SHALL implement the timer as sub-module bus_timer: inputs for the write strobes and masked write data; outputs for count, cmp, ctrl and irq.

Verification
REQ-029 SHALL cover masked write: write 0x10 data 0xFF mask 0x0F, then write data 0x00 mask 0x03 -> read of 0x10 returns 0x0C one cycle after address.
REQ-030 SHALL cover read-old-data: RAM[0x05]=0x11, then write 0x22 to 0x05 -> read_data=0x11 on the next cycle and 0x22 on the cycle after.
REQ-031 SHALL cover timer match: CMP=0x03, CTRL=0x05 with count 0 -> flag and irq set on the third enabled edge; write CTRL=0x07 -> irq clears.
REQ-032 SHALL cover timer wrap: COUNT=0xFE, enable on -> reads 0xFF then 0x00; with CMP=0x00 the flag sets on the wrap.
REQ-033 SHALL cover reset mid-write: assert reset while writing GPIO_OUT=0xA5 -> gpio_out=0x00 after reset, then ID reads 0x5A.
REQ-034 SHALL cover unmapped and compiled-out registers: read 0x80 -> 0x00; with the macro undefined, write 0xF2=0x33 -> read 0x00 and irq stays 0.
